// File: rtl/sprite_plotter.sv
// rtl/sprite_plotter.sv - W x H sprite erase/draw pixel generator for a 160x120 vga_adapter
// One pixel per clock; the outputs for each pixel are registered from the counters of the state being entered.
module sprite_plotter #(
   parameter int W = 8,
   parameter int H = 8,
   parameter logic [W*H-1:0] BITMAP = 64'h0,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] new_x,
   input  logic [6:0] new_y,
   input  logic [2:0] sprite_colour,
   input  logic       erase_en,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ERASE  = 2'd1;
   localparam logic [1:0] DRAW   = 2'd2;
   localparam logic [1:0] FINISH = 2'd3;

   localparam logic [3:0] LAST_DX = 4'(W - 1);
   localparam logic [3:0] LAST_DY = 4'(H - 1);

   logic [1:0] state, next_state;
   logic [3:0] dx, dy, nxt_dx, nxt_dy;
   logic [7:0] lat_x, prev_x, base_x;
   logic [6:0] lat_y, prev_y, base_y;
   logic [2:0] lat_colour, pix_colour;
   logic       have_prev;
   logic       scan, erasing, last;
   logic [8:0] sum_x;
   logic [7:0] sum_y;
   logic [7:0] bit_idx;
   logic [W*H-1:0] shifted;
   logic       in_bounds;

   assign last = (dx == LAST_DX) && (dy == LAST_DY);

   // Selects the pixel that will be visible during the next cycle.
   always_comb begin
      next_state = state;
      nxt_dx     = dx;
      nxt_dy     = dy;
      scan       = 1'b0;
      erasing    = 1'b0;
      base_x     = lat_x;
      base_y     = lat_y;
      pix_colour = lat_colour;
      case (state)
         IDLE: begin
            if (start) begin
               erasing    = erase_en && have_prev;
               next_state = erasing ? ERASE : DRAW;
               nxt_dx     = 4'd0;
               nxt_dy     = 4'd0;
               scan       = 1'b1;
               base_x     = erasing ? prev_x : new_x;
               base_y     = erasing ? prev_y : new_y;
               pix_colour = erasing ? BG_COLOUR : sprite_colour;
            end
         end
         ERASE: begin
            scan = 1'b1;
            if (last) begin
               next_state = DRAW;
               nxt_dx     = 4'd0;
               nxt_dy     = 4'd0;
            end else begin
               erasing    = 1'b1;
               base_x     = prev_x;
               base_y     = prev_y;
               pix_colour = BG_COLOUR;
               if (dx == LAST_DX) begin
                  nxt_dx = 4'd0;
                  nxt_dy = dy + 4'd1;
               end else begin
                  nxt_dx = dx + 4'd1;
               end
            end
         end
         DRAW: begin
            if (last) begin
               next_state = FINISH;
            end else begin
               scan = 1'b1;
               if (dx == LAST_DX) begin
                  nxt_dx = 4'd0;
                  nxt_dy = dy + 4'd1;
               end else begin
                  nxt_dx = dx + 4'd1;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign sum_x     = {1'b0, base_x} + {5'b0, nxt_dx};
   assign sum_y     = {1'b0, base_y} + {4'b0, nxt_dy};
   assign in_bounds = (sum_x < 9'd160) && (sum_y < 8'd120);
   assign bit_idx   = 8'(32'(nxt_dy) * W + 32'(nxt_dx));
   assign shifted   = BITMAP >> bit_idx;

   assign busy = (state != IDLE);
   assign done = (state == FINISH);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         dx         <= 4'd0;
         dy         <= 4'd0;
         lat_x      <= 8'd0;
         lat_y      <= 7'd0;
         lat_colour <= 3'd0;
         prev_x     <= 8'd0;
         prev_y     <= 7'd0;
         have_prev  <= 1'b0;
         x          <= 8'd0;
         y          <= 7'd0;
         colour     <= 3'd0;
         plot       <= 1'b0;
      end else begin
         state <= next_state;
         dx    <= nxt_dx;
         dy    <= nxt_dy;
         if (state == IDLE && start) begin
            lat_x      <= new_x;
            lat_y      <= new_y;
            lat_colour <= sprite_colour;
         end
         if (state == FINISH) begin
            prev_x    <= lat_x;
            prev_y    <= lat_y;
            have_prev <= 1'b1;
         end
         // Off-screen pixels still update x/y with the truncated sum but never strobe.
         if (scan) begin
            x      <= sum_x[7:0];
            y      <= sum_y[6:0];
            colour <= pix_colour;
            plot   <= in_bounds && (erasing || shifted[0]);
         end else begin
            plot   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sprite_plotter.sv
// tb/tb_sprite_plotter.sv - self-checking bench for sprite_plotter
// Expected pixels come from walking the box row-major with plain arithmetic.
module tb_sprite_plotter;

   localparam logic [63:0] BMP = 64'h8F3C_0A51_E6D2_7B19;
   localparam logic [2:0]  BG  = 3'b101;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] new_x = 8'd0;
   logic [6:0] new_y = 7'd0;
   logic [2:0] sprite_colour = 3'd0;
   logic       erase_en = 1'b0;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, busy, done;

   int vectors = 0;
   int miscompares = 0;
   int prev_x = 0;
   int prev_y = 0;
   bit have_prev = 1'b0;

   sprite_plotter #(.W(8), .H(8), .BITMAP(BMP), .BG_COLOUR(BG)) dut (
      .clock(clock), .reset(reset), .start(start), .new_x(new_x), .new_y(new_y),
      .sprite_colour(sprite_colour), .erase_en(erase_en), .x(x), .y(y),
      .colour(colour), .plot(plot), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_plot"}, plot, 0);
      chk({tag, "_x"}, x, 0);
      chk({tag, "_y"}, y, 0);
      chk({tag, "_colour"}, colour, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   // inject_at: cycle to pulse an ignored start; abort_at: cycle to assert reset.
   task automatic run_op(input int nx, input int ny, input int col, input bit er,
                         input int inject_at, input int abort_at);
      int e_n, total, idx, bx, by, cc, sx, sy;
      bit fg, pl;
      new_x = 8'(nx);
      new_y = 7'(ny);
      sprite_colour = 3'(col);
      erase_en = er;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      new_x = 8'($urandom);
      new_y = 7'($urandom);
      sprite_colour = 3'($urandom);
      erase_en = 1'($urandom);
      e_n = (er && have_prev) ? 64 : 0;
      total = e_n + 64 + 1;
      for (int c = 1; c <= total; c++) begin
         if (c == abort_at) begin
            #2 reset = 1'b1;
            #1;
            chk_idle_zero("abort");
            repeat (3) @(posedge clock);
            #1;
            chk_idle_zero("abort_hold");
            reset = 1'b0;
            have_prev = 1'b0;
            prev_x = 0;
            prev_y = 0;
            return;
         end
         if (c == inject_at) begin
            start = 1'b1;
            new_x = 8'((nx + 37) % 160);
            new_y = 7'((ny + 11) % 120);
            erase_en = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (c < total) begin
            if (c <= e_n) begin
               idx = c - 1; bx = prev_x; by = prev_y; cc = BG; fg = 1'b1;
            end else begin
               idx = c - 1 - e_n; bx = nx; by = ny; cc = col; fg = BMP[idx];
            end
            sx = bx + idx % 8;
            sy = by + idx / 8;
            pl = fg && (sx < 160) && (sy < 120);
            chk("plot", plot, pl);
            chk("x", x, sx % 256);
            chk("y", y, sy % 128);
            chk("colour", colour, cc);
            chk("busy", busy, 1);
            chk("done", done, 0);
         end else begin
            chk("fin_done", done, 1);
            chk("fin_busy", busy, 1);
            chk("fin_plot", plot, 0);
         end
         @(posedge clock); #1;
      end
      start = 1'b0;
      chk("after_busy", busy, 0);
      chk("after_done", done, 0);
      chk("after_plot", plot, 0);
      prev_x = nx;
      prev_y = ny;
      have_prev = 1'b1;
   endtask

   initial begin
      int nx, ny, col, inj;
      bit er;
      repeat (2) @(posedge clock);
      #1;
      chk_idle_zero("reset");
      reset = 1'b0;
      @(posedge clock); #1;
      run_op(50, 30, 1, 1'b0, 0, 17);
      run_op(50, 30, 1, 1'b0, 0, 0);
      run_op(60, 40, 3, 1'b1, 0, 23);
      run_op(10, 20, 3'b010, 1'b1, 0, 0);
      run_op(12, 20, 3'b100, 1'b1, 0, 0);
      run_op(156, 116, 3'b110, 1'b1, 100, 0);
      run_op(40, 40, 3'b111, 1'b0, 20, 0);
      run_op(200, 125, 3'b001, 1'b0, 0, 0);
      run_op(0, 0, 3'b011, 1'b1, 5, 0);
      for (int i = 0; i < 12; i++) begin
         nx  = int'($urandom_range(0, 175));
         ny  = int'($urandom_range(0, 127));
         col = int'($urandom_range(0, 7));
         er  = 1'($urandom);
         inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 60)) : 0;
         run_op(nx, ny, col, er, inj, 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
